// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the memory arbiter slice.
//   state_t : arbiter sequencer states (IDLE = 0, ISSUE = 1, RDWAIT = 2)
//   REQ_DP  : requester id of the processor data path
//   REQ_LD  : requester id of the loader/debug port
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  localparam logic REQ_DP = 1'b0;
  localparam logic REQ_LD = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the two requester handshakes and the memory port
// pair of the arbiter.
//   requester side : req/we/addr/wdata in, gnt/rvalid/rdata out (x2)
//   memory side    : mem_write/mem_waddr/mem_raddr/mem_din out, mem_dout in
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters plus memory)
interface mem_arbiter_if #(
  parameter int width  = 32,
  parameter int awidth = 5
) ();

  logic              req0,    req1;
  logic              we0,     we1;
  logic [awidth-1:0] addr0,   addr1;
  logic [width-1:0]  wdata0,  wdata1;
  logic              gnt0,    gnt1;
  logic              rvalid0, rvalid1;
  logic [width-1:0]  rdata0,  rdata1;

  logic              mem_write;
  logic [awidth-1:0] mem_waddr;
  logic [awidth-1:0] mem_raddr;
  logic [width-1:0]  mem_din;
  logic [width-1:0]  mem_dout;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_write, mem_waddr, mem_raddr, mem_din
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_write, mem_waddr, mem_raddr, mem_din
  );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker.
//   req0, req1 : pending requests
//   last       : id of the requester granted most recently
//   valid      : at least one request is pending
//   winner     : id of the requester to serve next
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic winner
);

  assign valid = req0 | req1;

  // A lone requester always wins; on a tie the one not served last wins.
  assign winner = (req0 && req1) ? ~last : (req1 ? REQ_LD : REQ_DP);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter and sequencer in front of a
// memory with one write port and one synchronous read port.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : requester handshakes and memory ports (mem_arbiter_if.slave)
// Parameters: width (data bits), depth (memory words), awidth (address bits).
// Writes take 2 cycles per access, reads 3 (the extra cycle covers the
// synchronous read latency of the memory).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int width  = 32,
  parameter int depth  = 32,
  parameter int awidth = 5
) (
  input logic           clk,
  input logic           reset,
  mem_arbiter_if.slave  bus
);

  state_t            state_q,     state_d;
  logic              last_q,      last_d;
  logic              id_q,        id_d;
  logic              we_q,        we_d;
  logic              in_range_q,  in_range_d;
  logic              gnt0_q,      gnt0_d;
  logic              gnt1_q,      gnt1_d;
  logic              rvalid0_q,   rvalid0_d;
  logic              rvalid1_q,   rvalid1_d;
  logic [width-1:0]  rdata0_q,    rdata0_d;
  logic [width-1:0]  rdata1_q,    rdata1_d;
  logic              mem_write_q, mem_write_d;
  logic [awidth-1:0] mem_waddr_q, mem_waddr_d;
  logic [awidth-1:0] mem_raddr_q, mem_raddr_d;
  logic [width-1:0]  mem_din_q,   mem_din_d;

  logic              pick_valid;
  logic              pick_winner;
  logic              sel_we;
  logic [awidth-1:0] sel_addr;
  logic [width-1:0]  sel_wdata;
  logic              sel_in_range;

  rr_pick2 u_pick (
    .req0   (bus.req0),
    .req1   (bus.req1),
    .last   (last_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  assign sel_we       = pick_winner ? bus.we1    : bus.we0;
  assign sel_addr     = pick_winner ? bus.addr1  : bus.addr0;
  assign sel_wdata    = pick_winner ? bus.wdata1 : bus.wdata0;
  assign sel_in_range = (32'(sel_addr) < 32'(depth));

  // Grant, memory controls and the ISSUE state are all loaded on the same
  // edge that latches the winner, so every output is a flop.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    we_d        = we_q;
    in_range_d  = in_range_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    mem_write_d = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_raddr_d = mem_raddr_q;
    mem_din_d   = mem_din_q;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          id_d        = pick_winner;
          last_d      = pick_winner;
          we_d        = sel_we;
          in_range_d  = sel_in_range;
          gnt0_d      = (pick_winner == REQ_DP);
          gnt1_d      = (pick_winner == REQ_LD);
          // Out-of-range writes are granted but never reach the memory.
          mem_write_d = sel_we & sel_in_range;
          mem_waddr_d = sel_addr;
          mem_raddr_d = sel_addr;
          mem_din_d   = sel_wdata;
          state_d     = ISSUE;
        end
      end

      ISSUE: begin
        state_d = we_q ? IDLE : RDWAIT;
      end

      RDWAIT: begin
        // mem_dout now reflects mem_raddr driven during ISSUE.
        if (id_q == REQ_DP) begin
          rdata0_d  = in_range_q ? bus.mem_dout : '0;
          rvalid0_d = 1'b1;
        end else begin
          rdata1_d  = in_range_q ? bus.mem_dout : '0;
          rvalid1_d = 1'b1;
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= REQ_LD;
      id_q        <= REQ_DP;
      we_q        <= 1'b0;
      in_range_q  <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      mem_write_q <= 1'b0;
      mem_waddr_q <= '0;
      mem_raddr_q <= '0;
      mem_din_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      we_q        <= we_d;
      in_range_q  <= in_range_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      mem_write_q <= mem_write_d;
      mem_waddr_q <= mem_waddr_d;
      mem_raddr_q <= mem_raddr_d;
      mem_din_q   <= mem_din_d;
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.rvalid0   = rvalid0_q;
  assign bus.rvalid1   = rvalid1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_waddr = mem_waddr_q;
  assign bus.mem_raddr = mem_raddr_q;
  assign bus.mem_din   = mem_din_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter (width 32, depth 32,
// awidth 6 so that out-of-range addresses can be presented).
// Contains a small synchronous-read memory, a table of single accesses, a
// read-data scoreboard and hand-written tie/reset/interleave sequences.
module tb_mem_arbiter;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 6;

  logic clk;
  logic reset;

  mem_arbiter_if #(.width(W), .awidth(AW)) bus ();

  mem_arbiter #(.width(W), .depth(D), .awidth(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: synchronous read, word i starts out as 14*i + 4 (word 10 = 144).
  logic [W-1:0] mem [D];
  logic         mem_loaded = 1'b0;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < D; i++) mem[i] <= 32'(14 * i + 4);
      mem_loaded <= 1'b1;
    end else if (bus.mem_write && (32'(bus.mem_waddr) < 32'(D))) begin
      mem[bus.mem_waddr[4:0]] <= bus.mem_din;
    end
    bus.mem_dout <= mem[bus.mem_raddr[4:0]];
  end

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic         id;
    logic [W-1:0] data;
  } sb_t;

  sb_t sb_q[$];

  typedef struct {
    logic          id;
    logic          we;
    logic [AW-1:0] addr;
    logic [W-1:0]  wdata;
    logic          exp_write;
    logic [W-1:0]  exp_rdata;
    int            gap;
  } vec_t;

  vec_t vecs[12];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t",
               name, actual, expected, $time);
    end
  endtask

  task automatic checkRead(input logic id, input logic [W-1:0] data);
    sb_t e;
    if (sb_q.size() == 0) begin
      checkOutput("unexpected_rvalid", 32'(id), 32'hffff_ffff);
    end else begin
      e = sb_q.pop_front();
      checkOutput("rvalid_id", 32'(id), 32'(e.id));
      checkOutput("rdata", data, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (bus.rvalid0) checkRead(1'b0, bus.rdata0);
    if (bus.rvalid1) checkRead(1'b1, bus.rdata1);
  end

  task automatic drive(input logic id, input logic req, input logic we,
                       input logic [AW-1:0] addr, input logic [W-1:0] wdata);
    if (id) begin
      bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
    end else begin
      bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
    end
  endtask

  // which: 0 gnt0, 1 gnt1, 2 rvalid0, 3 rvalid1, 4 either gnt.
  task automatic waitFor(input int which, output int n);
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 12) begin
      @(negedge clk);
      n++;
      case (which)
        0:       seen = bus.gnt0;
        1:       seen = bus.gnt1;
        2:       seen = bus.rvalid0;
        3:       seen = bus.rvalid1;
        default: seen = bus.gnt0 | bus.gnt1;
      endcase
    end
  endtask

  // Called just after a rising edge with the arbiter idle.
  task automatic applyStimulus(input vec_t v, output time gnt_t);
    int n;
    drive(v.id, 1'b1, v.we, v.addr, v.wdata);
    if (!v.we) sb_q.push_back('{id: v.id, data: v.exp_rdata});
    waitFor(v.id ? 1 : 0, n);
    gnt_t = $time;
    checkOutput("gnt_latency", 32'(n), 32'd2);
    checkOutput("other_gnt", 32'(v.id ? bus.gnt0 : bus.gnt1), 32'd0);
    checkOutput("mem_write", 32'(bus.mem_write), 32'(v.exp_write));
    if (v.we) begin
      checkOutput("mem_waddr", 32'(bus.mem_waddr), 32'(v.addr));
      checkOutput("mem_din", bus.mem_din, v.wdata);
    end else begin
      checkOutput("mem_raddr", 32'(bus.mem_raddr), 32'(v.addr));
    end
    @(posedge clk); #1;
    drive(v.id, 1'b0, 1'b0, '0, '0);
    if (!v.we) begin
      waitFor(v.id ? 3 : 2, n);
      checkOutput("rvalid_latency", 32'(n), 32'd2);
      @(posedge clk); #1;
    end
  endtask

  task automatic tieReads(input logic [AW-1:0] addr, input logic [W-1:0] exp);
    int n;
    drive(1'b0, 1'b1, 1'b0, addr, '0);
    drive(1'b1, 1'b1, 1'b0, addr, '0);
    sb_q.push_back('{id: 1'b0, data: exp});
    sb_q.push_back('{id: 1'b1, data: exp});
    waitFor(4, n);
    checkOutput("tie_latency", 32'(n), 32'd2);
    checkOutput("tie_first_gnt0", 32'(bus.gnt0), 32'd1);
    checkOutput("tie_first_gnt1", 32'(bus.gnt1), 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    waitFor(1, n);
    checkOutput("tie_second_gap", 32'(n), 32'd3);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    waitFor(3, n);
    checkOutput("tie_rvalid1_latency", 32'(n), 32'd2);
    @(posedge clk); #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    time t;
    time prev;
    int  n;

    vecs[0]  = '{1'b0, 1'b1, 6'd13, 32'd134,        1'b1, 32'd0,          0};
    vecs[1]  = '{1'b0, 1'b0, 6'd13, 32'd0,          1'b0, 32'd134,        0};
    vecs[2]  = '{1'b1, 1'b1, 6'd10, 32'd170,        1'b1, 32'd0,          0};
    vecs[3]  = '{1'b1, 1'b1, 6'd11, 32'd200,        1'b1, 32'd0,          20};
    vecs[4]  = '{1'b1, 1'b0, 6'd10, 32'd0,          1'b0, 32'd170,        0};
    vecs[5]  = '{1'b0, 1'b0, 6'd11, 32'd0,          1'b0, 32'd200,        0};
    vecs[6]  = '{1'b0, 1'b1, 6'd31, 32'd77,         1'b1, 32'd0,          0};
    vecs[7]  = '{1'b1, 1'b0, 6'd31, 32'd0,          1'b0, 32'd77,         0};
    vecs[8]  = '{1'b0, 1'b1, 6'd32, 32'd55,         1'b0, 32'd0,          0};
    vecs[9]  = '{1'b1, 1'b0, 6'd32, 32'd0,          1'b0, 32'd0,          0};
    vecs[10] = '{1'b1, 1'b1, 6'd0,  32'hdeadbeef,   1'b1, 32'd0,          0};
    vecs[11] = '{1'b0, 1'b0, 6'd0,  32'd0,          1'b0, 32'hdeadbeef,   0};

    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    doReset();

    @(negedge clk);
    checkOutput("rst_gnt0",      32'(bus.gnt0),      32'd0);
    checkOutput("rst_gnt1",      32'(bus.gnt1),      32'd0);
    checkOutput("rst_rvalid0",   32'(bus.rvalid0),   32'd0);
    checkOutput("rst_rvalid1",   32'(bus.rvalid1),   32'd0);
    checkOutput("rst_mem_write", 32'(bus.mem_write), 32'd0);
    checkOutput("rst_rdata0",    bus.rdata0,         32'd0);
    checkOutput("rst_rdata1",    bus.rdata1,         32'd0);
    checkOutput("rst_mem_waddr", 32'(bus.mem_waddr), 32'd0);
    checkOutput("rst_mem_raddr", 32'(bus.mem_raddr), 32'd0);
    checkOutput("rst_mem_din",   bus.mem_din,        32'd0);
    @(posedge clk); #1;

    tieReads(6'd10, 32'd144);
    tieReads(6'd10, 32'd144);

    prev = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i], t);
      if (vecs[i].gap != 0) checkOutput("gnt_gap", 32'(t - prev), 32'(vecs[i].gap));
      prev = t;
    end
    repeat (2) @(posedge clk);
    #1;
    checkOutput("mem10", mem[10], 32'd170);
    checkOutput("mem11", mem[11], 32'd200);
    checkOutput("mem31", mem[31], 32'd77);
    checkOutput("mem13", mem[13], 32'd134);

    // Reset while a write sits in ISSUE.
    drive(1'b0, 1'b1, 1'b1, 6'd13, 32'd210);
    @(posedge clk);
    #1 checkOutput("pre_reset_gnt0", 32'(bus.gnt0), 32'd1);
    #1 reset = 1'b1;
    #1;
    checkOutput("issue_reset_gnt0",      32'(bus.gnt0),      32'd0);
    checkOutput("issue_reset_mem_write", 32'(bus.mem_write), 32'd0);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("issue_reset_mem13", mem[13], 32'd134);

    // Reset while a read sits in RDWAIT.
    drive(1'b1, 1'b1, 1'b0, 6'd13, '0);
    @(posedge clk);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    #1 reset = 1'b1;
    #1 checkOutput("rdwait_reset_rvalid1", 32'(bus.rvalid1), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rdwait_no_rvalid1", 32'(bus.rvalid1), 32'd0);
    end
    checkOutput("rdwait_rdata1", bus.rdata1, 32'd0);
    @(posedge clk); #1;

    // Interleave: requester 0 reads addr 13 while requester 1 writes it.
    doReset();
    drive(1'b0, 1'b1, 1'b0, 6'd13, '0);
    drive(1'b1, 1'b1, 1'b1, 6'd13, 32'd201);
    sb_q.push_back('{id: 1'b0, data: 32'd134});
    waitFor(4, n);
    checkOutput("il_first_latency", 32'(n), 32'd2);
    checkOutput("il_first_gnt0", 32'(bus.gnt0), 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    waitFor(1, n);
    checkOutput("il_gnt1_gap", 32'(n), 32'd3);
    checkOutput("il_mem_write", 32'(bus.mem_write), 32'd1);
    checkOutput("il_mem_waddr", 32'(bus.mem_waddr), 32'd13);
    checkOutput("il_mem_din", bus.mem_din, 32'd201);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    applyStimulus('{1'b0, 1'b0, 6'd13, 32'd0, 1'b0, 32'd201, 0}, t);
    checkOutput("il_mem13", mem[13], 32'd201);

    repeat (3) @(negedge clk);
    checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester round-robin arbiter and sequencer in front of the single-port-pair data memory (one write port, one synchronous read port). Each requester issues one read or write at a time using a req/gnt handshake. The arbiter serialises the accesses, drives the memory write and read ports, and returns read data with a one-cycle `rvalid` pulse. It sits between the processor's load/store paths (requester 0 = data path, requester 1 = loader/debug) and the memory block.

## Interface
- `width`, 32, data word width
- `depth`, 32, number of memory words
- `awidth`, 5, address width (≥ clog2(depth))

- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `req0`, `req1`  in  1  access request
- `we0`, `we1`  in  1  1 = write, 0 = read
- `addr0`, `addr1`  in  awidth  word address
- `wdata0`, `wdata1`  in  width  write data
- `gnt0`, `gnt1`  out  1  one-cycle grant pulse
- `rvalid0`, `rvalid1`  out  1  one-cycle read-data-valid pulse
- `rdata0`, `rdata1`  out  width  read data, held until next read by the same requester
- `mem_write`  out  1  memory write enable
- `mem_waddr`, `mem_raddr`  out  awidth  memory addresses
- `mem_din`  out  width  memory write data
- `mem_dout`  in  width  memory read data, valid one cycle after `mem_raddr`

## Operation
- FSM states: IDLE, ISSUE, RDWAIT.
- IDLE: if any `req` is high, latch the winner id and its `we`, `addr` and `wdata`, then go to ISSUE. Otherwise stay in IDLE.
- ISSUE: pulse the winner's `gnt`. Drive `mem_waddr`/`mem_raddr`/`mem_din` from the latched values. `mem_write` = latched `we` AND address in range. Next state is IDLE for a write, RDWAIT for a read.
- RDWAIT: on the clock edge, `rdata<id>` ← `mem_dout` (or 0 if the address is out of range) and `rvalid<id>` ← 1. Next state is IDLE.
- Arbitration: a single requester always wins. On a tie, the winner is the requester not granted last. The `last` pointer resets to 1, so requester 0 wins the first tie. `last` updates on each latch.
- Handshake: `req`, `we`, `addr` and `wdata` stay stable from assertion through the `gnt` cycle inclusive. In the cycle after `gnt` the requester deasserts `req` or presents its next request. `req` is ignored outside IDLE.
- Out-of-range address (`addr` ≥ `depth`): the requester is still granted. A write is dropped (`mem_write` stays 0). A read returns `rdata` = 0 with `rvalid`.
- Reset values: state IDLE, `last` = 1, all `gnt`/`rvalid`/`mem_write` = 0, `rdata0`/`rdata1`/`mem_waddr`/`mem_raddr`/`mem_din` = 0.

## Timing
- Request sampled in IDLE at the end of cycle k → `gnt` in cycle k+1 (the ISSUE cycle).
- Write: committed at the k+1/k+2 edge. The next arbitration is at the end of k+2, so writes sustain one access every 2 cycles.
- Read: `mem_raddr` is driven in k+1, `mem_dout` is sampled at the end of k+2, and `rvalid` is high in k+3. The arbiter is back in IDLE in k+3, so reads sustain one access every 3 cycles.
- `gnt` and `rvalid` are registered and never high for more than one consecutive cycle per access.
- Reset mid-operation: all outputs clear immediately.
  - A write in ISSUE is not committed.
  - A read in RDWAIT produces no `rvalid`.
  - Both requests are lost and must be re-issued.
- Simultaneous `rvalid` for one requester and a `gnt` for the other in the same cycle is legal.

## Structure
- Package `mem_arb_pkg`:
  - state encoding IDLE = 0, ISSUE = 1, RDWAIT = 2
  - requester id constants REQ_DP = 0, REQ_LD = 1
- Sub-module `rr_pick2`: combinational 2-way round-robin picker. Inputs are `req0`, `req1` and `last`; outputs are `valid` and `winner`. Everything else stays in `mem_arbiter`.

## Test plan
- Single write then read: req0, we0 = 1, addr0 = 13, wdata0 = 134 → `gnt0` one cycle later with `mem_write` = 1, `mem_waddr` = 13. A read of addr 13 → `rvalid0` 3 cycles after the request, `rdata0` = 134.
- Tie: req0 and req1 both reading addr 10 (holding 144) from reset → requester 0 is granted first and requester 1 next. Both get `rdata` = 144. The next tie goes to requester 0 again.
- Back-to-back writes by requester 1 to addr 10 then 11 (values 170, 200) → `gnt1` pulses 2 cycles apart. Memory words 10 = 170 and 11 = 200.
- Out of range: depth = 32, write to addr 31 is accepted. A request to addr 32 with a 6-bit address → granted with no `mem_write`. A read of addr 32 → `rvalid` with `rdata` = 0.
- Reset during ISSUE of a write of 210 to addr 13 → no `gnt`, no `mem_write`, and addr 13 keeps its old value. Reset during RDWAIT → no `rvalid`.
- Interleave: requester 0 reads while requester 1 writes 201 to addr 13 → `rvalid0` and `gnt1` may coincide, and each `rdata` reflects memory contents at its own ISSUE.
